// File: rtl/demux_1_n_stream.sv
// Registered 1:N stream demultiplexer with valid/ready on both sides and a one-entry register per channel.
// Optional broadcast routing is enabled by defining DEMUX_1_N_BROADCAST_EN.
module demux_1_n_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned SEL_WIDTH  = 2
) (
    input  logic                         Clock_In,
    input  logic                         Reset_n_In,
    input  logic                         Enable_In,
    input  logic [DATA_WIDTH-1:0]        Data_In,
    input  logic                         Valid_In,
    output logic                         Ready_Out,
    input  logic [SEL_WIDTH-1:0]         Select_In,
    input  logic                         Broadcast_In,
    output logic [NUM_CH*DATA_WIDTH-1:0] Data_Out,
    output logic [NUM_CH-1:0]            Valid_Out,
    input  logic [NUM_CH-1:0]            Ready_In,
    output logic                         Select_Error_Out
);

    logic [NUM_CH-1:0]     free;
    logic [NUM_CH-1:0]     load;
    logic [NUM_CH-1:0]     valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_q [NUM_CH];
    logic                  sel_in_range;
    logic                  sel_free;
    logic                  route_ready;
    logic                  broadcast;
    logic                  accept;
    logic                  error_d, error_q;

    // A channel can take a word if empty or being drained in this same cycle.
    assign free = ~valid_q | Ready_In;

    // Zero-extend the select so NUM_CH == 2**SEL_WIDTH compares correctly.
    always_comb begin
        sel_in_range = 32'(Select_In) < NUM_CH;
        sel_free     = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (32'(Select_In) == k) begin
                sel_free = free[k];
            end
        end
    end

`ifdef DEMUX_1_N_BROADCAST_EN
    assign broadcast   = Broadcast_In;
    assign route_ready = broadcast ? (&free) : (!sel_in_range || sel_free);
`else
    logic unused_broadcast;
    assign unused_broadcast = Broadcast_In;
    assign broadcast        = 1'b0;
    assign route_ready      = !sel_in_range || sel_free;
`endif

    assign Ready_Out = Enable_In & route_ready;
    assign accept    = Valid_In & Ready_Out;

    always_comb begin
        load    = '0;
        valid_d = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            load[k]    = accept & (broadcast | (32'(Select_In) == k));
            valid_d[k] = load[k] | (valid_q[k] & ~Ready_In[k]);
        end
    end

    // Out-of-range words are swallowed; only the error pulse records them.
    assign error_d = accept & ~broadcast & ~sel_in_range;

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            valid_q <= '0;
            error_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (load[k]) begin
                    data_q[k] <= Data_In;
                end
            end
        end
    end

    always_comb begin
        Data_Out = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            Data_Out[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
        end
    end

    assign Valid_Out        = valid_q;
    assign Select_Error_Out = error_q;

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Bench for demux_1_n_stream: a 4-channel and a 3-channel instance share stimulus and are
// compared each cycle against a per-word routing model plus directed scenario checks.
module tb_demux_1_n_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, vin, bc;
    logic [7:0]  din;
    logic [1:0]  sel;
    logic [3:0]  rdy;
    logic        rdy4, rdy3, err4, err3;
    logic [31:0] dout4;
    logic [23:0] dout3;
    logic [3:0]  vout4;
    logic [2:0]  vout3;

    int errors = 0;
    int checks = 0;

    // Reference state: per instance, per channel, the word held and whether it is pending.
    bit         m_v   [2][4];
    logic [7:0] m_d   [2][4];
    bit         m_err [2];

    always #5 clk = ~clk;

    demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2)) dut4 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en), .Data_In(din), .Valid_In(vin),
        .Ready_Out(rdy4), .Select_In(sel), .Broadcast_In(bc), .Data_Out(dout4),
        .Valid_Out(vout4), .Ready_In(rdy), .Select_Error_Out(err4)
    );

    demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CH(3), .SEL_WIDTH(2)) dut3 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en), .Data_In(din), .Valid_In(vin),
        .Ready_Out(rdy3), .Select_In(sel), .Broadcast_In(bc), .Data_Out(dout3),
        .Valid_Out(vout3), .Ready_In(rdy[2:0]), .Select_Error_Out(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit bc_on();
`ifdef DEMUX_1_N_BROADCAST_EN
        return bc;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int nch(input int u);
        return (u == 0) ? 4 : 3;
    endfunction

    function automatic bit m_ready(input int u);
        int n = nch(u);
        if (!en) return 1'b0;
        if (bc_on()) begin
            for (int k = 0; k < n; k++) if (m_v[u][k] && !rdy[k]) return 1'b0;
            return 1'b1;
        end
        if (int'(sel) >= n) return 1'b1;
        return !m_v[u][sel] || rdy[sel];
    endfunction

    task automatic m_clear();
        for (int u = 0; u < 2; u++) begin
            m_err[u] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_v[u][k] = 1'b0;
                m_d[u][k] = 8'h00;
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ev, ed;
        for (int u = 0; u < 2; u++) begin
            ev = '0;
            ed = '0;
            for (int k = 0; k < nch(u); k++) begin
                ev[k]       = m_v[u][k];
                ed[k*8 +: 8] = m_d[u][k];
            end
            if (u == 0) begin
                check("valid4", {28'b0, vout4}, ev);
                check("data4", dout4, ed);
                check("err4", {31'b0, err4}, {31'b0, m_err[0]});
            end else begin
                check("valid3", {29'b0, vout3}, ev);
                check("data3", {8'b0, dout3}, ed);
                check("err3", {31'b0, err3}, {31'b0, m_err[1]});
            end
        end
    endtask

    // One clock: check Ready_Out on current inputs, advance the model at the edge, check outputs.
    task automatic step();
        bit exp_rdy [2];
        bit acc;
        int n;
        #1;
        for (int u = 0; u < 2; u++) exp_rdy[u] = m_ready(u);
        check("ready4", {31'b0, rdy4}, {31'b0, exp_rdy[0]});
        check("ready3", {31'b0, rdy3}, {31'b0, exp_rdy[1]});
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            n   = nch(u);
            acc = vin && exp_rdy[u];
            m_err[u] = acc && !bc_on() && (int'(sel) >= n);
            for (int k = 0; k < n; k++) if (m_v[u][k] && rdy[k]) m_v[u][k] = 1'b0;
            if (acc) begin
                for (int k = 0; k < n; k++) begin
                    if (bc_on() || int'(sel) == k) begin
                        m_v[u][k] = 1'b1;
                        m_d[u][k] = din;
                    end
                end
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic [3:0] held;
        rst_n = 1'b0;
        en = 1'b0; vin = 1'b0; bc = 1'b0; din = 8'h00; sel = 2'd0; rdy = 4'h0;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        check("reset_ready_disabled", {31'b0, rdy4}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word to channel 2, then it drains.
        en = 1'b1; rdy = 4'hF; vin = 1'b1; din = 8'hA5; sel = 2'd2;
        step();
        check("a5_valid", {28'b0, vout4}, 32'h4);
        check("a5_data", {24'b0, dout4[23:16]}, 32'hA5);
        vin = 1'b0;
        step();
        check("a5_drained", {28'b0, vout4}, 32'h0);

        // Channel 1 stalled: second word to ch1 is refused, ch3 still accepted.
        rdy = 4'b1101; vin = 1'b1; din = 8'h11; sel = 2'd1;
        step();
        din = 8'h22;
        #1;
        check("stall_ready", {31'b0, rdy4}, 32'd0);
        step();
        check("stall_hold", {24'b0, dout4[15:8]}, 32'h11);
        din = 8'h33; sel = 2'd3;
        step();
        check("ch3_data", {24'b0, dout4[31:24]}, 32'h33);
        check("ch1_still", {31'b0, vout4[1]}, 32'd1);
        vin = 1'b0; rdy = 4'hF;
        step();

        // Back-to-back words to channel 0 at full throughput.
        vin = 1'b1; sel = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            din = 8'(i);
            step();
            check("b2b_data", {24'b0, dout4[7:0]}, i);
            check("b2b_ready", {31'b0, rdy4}, 32'd1);
        end
        vin = 1'b0;
        step();

        // Out-of-range select on the 3-channel instance.
        rdy = 4'b0000; vin = 1'b1; din = 8'h44; sel = 2'd1;
        step();
        held = {1'b0, vout3};
        sel = 2'd3; din = 8'h99;
        step();
        check("oor_err", {31'b0, err3}, 32'd1);
        check("oor_valid", {28'b0, 1'b0, vout3}, {28'b0, held});
        vin = 1'b0;
        step();
        check("oor_pulse", {31'b0, err3}, 32'd0);
        rdy = 4'hF;
        step();

        // Enable low: no accept, registered word still drains.
        rdy = 4'b1011; vin = 1'b1; din = 8'h5A; sel = 2'd2;
        step();
        en = 1'b0; rdy = 4'hF; din = 8'h66;
        #1;
        check("dis_ready", {31'b0, rdy4}, 32'd0);
        step();
        check("dis_drained", {28'b0, vout4}, 32'h0);
        check("dis_keep", {24'b0, dout4[23:16]}, 32'h5A);
        en = 1'b1; vin = 1'b0;

`ifdef DEMUX_1_N_BROADCAST_EN
        // Broadcast waits for every channel to be free.
        rdy = 4'b1110; vin = 1'b1; din = 8'h77; sel = 2'd0;
        step();
        bc = 1'b1; din = 8'hC3;
        #1;
        check("bc_blocked", {31'b0, rdy4}, 32'd0);
        step();
        rdy = 4'hF;
        step();
        check("bc_valid", {28'b0, vout4}, 32'hF);
        check("bc_data", dout4, 32'hC3C3C3C3);
        bc = 1'b0; vin = 1'b0;
        step();
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            vin = $urandom_range(0, 1);
            bc  = ($urandom_range(0, 7) == 0);
            din = 8'($urandom);
            sel = 2'($urandom);
            rdy = 4'($urandom);
            step();
        end

        // Asynchronous reset mid-cycle clears everything immediately.
        vin = 1'b1; en = 1'b1; bc = 1'b0; sel = 2'd1; rdy = 4'h0; din = 8'hEE;
        step();
        vin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_clear();
        check("rst_valid4", {28'b0, vout4}, 32'h0);
        check("rst_valid3", {29'b0, vout3}, 32'h0);
        check_outputs();
        #1 rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
